// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: rebuilds x/y/pixel coordinates from hsync/vsync/display_on,
// measures line period and frame height, and tracks timing lock against the expected raster.
module vga_sync_decoder #(
  parameter int H_SIZE      = 10,
  parameter int V_SIZE      = 10,
  parameter int P_SIZE      = 19,
  parameter int EXP_H_COUNT = 800,
  parameter int EXP_V_COUNT = 525,
  parameter int LOCK_FRAMES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vga_hsync,
  input  logic              vga_vsync,
  input  logic              display_on,
  output logic              pixel_valid,
  output logic [H_SIZE-1:0] x_addr,
  output logic [V_SIZE-1:0] y_addr,
  output logic [P_SIZE-1:0] pixel_addr,
  output logic [H_SIZE-1:0] h_period,
  output logic [V_SIZE-1:0] v_lines,
  output logic              frame_start,
  output logic              locked,
  output logic              timing_err
);

  // h_cnt must reach the hsync-lost threshold even when that exceeds the h_period width
  localparam int HC_W = ($clog2(2 * EXP_H_COUNT) > H_SIZE) ? $clog2(2 * EXP_H_COUNT) : H_SIZE;
  localparam logic [HC_W-1:0]   H_LOST = HC_W'(2 * EXP_H_COUNT - 1);
  localparam logic [HC_W:0]     H_EXP  = (HC_W + 1)'(EXP_H_COUNT);
  localparam logic [V_SIZE-1:0] V_EXP  = V_SIZE'(EXP_V_COUNT);
  localparam logic [2:0]        LOCK_N = 3'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t            state, state_n;
  logic [2:0]        match_cnt, match_n;
  logic              err_n;

  logic              hs_q, vs_q, de_q;
  logic              hs_d, vs_d, de_d;
  logic              hs_fall, vs_fall, de_fall;

  logic [HC_W-1:0]   h_cnt;
  logic [HC_W:0]     h_next;
  logic              h_seen;
  logic              h_ok;
  logic [V_SIZE-1:0] line_cnt;
  logic [V_SIZE-1:0] lines_now;
  logic              h_bad, lines_ok, good_frame, h_lost;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      de_q <= 1'b0;
      hs_d <= 1'b0;
      vs_d <= 1'b0;
      de_d <= 1'b0;
    end else begin
      hs_q <= vga_hsync;
      vs_q <= vga_vsync;
      de_q <= display_on;
      hs_d <= hs_q;
      vs_d <= vs_q;
      de_d <= de_q;
    end
  end

  assign hs_fall = hs_d & ~hs_q;
  assign vs_fall = vs_d & ~vs_q;
  assign de_fall = de_d & ~de_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel_valid <= 1'b0;
      x_addr      <= '0;
      y_addr      <= '0;
      pixel_addr  <= '0;
    end else begin
      pixel_valid <= de_q;
      x_addr      <= (de_q && pixel_valid) ? x_addr + H_SIZE'(1) : '0;
      if (vs_fall) begin
        y_addr     <= '0;
        pixel_addr <= '0;
      end else begin
        if (de_fall)     y_addr     <= y_addr + V_SIZE'(1);
        if (pixel_valid) pixel_addr <= pixel_addr + P_SIZE'(1);
      end
    end
  end

  // A coincident hs_fall belongs to the frame that the vs_fall is closing
  assign h_next     = {1'b0, h_cnt} + (HC_W + 1)'(1);
  assign h_bad      = hs_fall && h_seen && (h_next != H_EXP);
  assign lines_now  = line_cnt + V_SIZE'(hs_fall);
  assign lines_ok   = (lines_now == V_EXP);
  assign good_frame = h_ok && !h_bad && lines_ok;
  assign h_lost     = (state != SEARCH) && (h_cnt == H_LOST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt       <= '0;
      h_seen      <= 1'b0;
      h_period    <= '0;
      line_cnt    <= '0;
      v_lines     <= '0;
      h_ok        <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= vs_fall;
      if (hs_fall)             h_cnt <= '0;
      else if (h_cnt != '1)    h_cnt <= h_cnt + HC_W'(1);
      if (h_lost)              h_seen <= 1'b0;
      else if (hs_fall)        h_seen <= 1'b1;
      if (hs_fall)             h_period <= H_SIZE'(h_next);
      if (vs_fall) begin
        line_cnt <= '0;
        v_lines  <= lines_now;
      end else if (hs_fall) begin
        line_cnt <= line_cnt + V_SIZE'(1);
      end
      if (vs_fall)             h_ok <= 1'b1;
      else if (h_bad)          h_ok <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SEARCH;
      match_cnt  <= '0;
      timing_err <= 1'b0;
    end else begin
      state      <= state_n;
      match_cnt  <= match_n;
      timing_err <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    match_n = match_cnt;
    err_n   = 1'b0;
    case (state)
      SEARCH: begin
        if (vs_fall) begin
          state_n = TRACK;
          match_n = '0;
        end
      end
      TRACK: begin
        if (h_lost) begin
          state_n = SEARCH;
          match_n = '0;
        end else if (vs_fall) begin
          if (good_frame) begin
            match_n = match_cnt + 3'd1;
            if (match_cnt + 3'd1 == LOCK_N) state_n = LOCKED;
          end else begin
            match_n = '0;
          end
        end
      end
      LOCKED: begin
        if (h_lost) begin
          state_n = SEARCH;
          match_n = '0;
          err_n   = 1'b1;
        end else if (h_bad || (vs_fall && !lines_ok)) begin
          state_n = TRACK;
          match_n = '0;
          err_n   = 1'b1;
        end
      end
      default: begin
        state_n = SEARCH;
        match_n = '0;
      end
    endcase
  end

  always_comb begin
    locked = (state == LOCKED);
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a scaled-down 20x10 raster (12x6 active) so that
// many frames, a short line, hsync loss and a mid-frame reset fit in a short run.
module tb_vga_sync_decoder;

  localparam int H_TOT  = 20;
  localparam int H_SYNC = 3;
  localparam int H_ACT0 = 6;
  localparam int H_ACT  = 12;
  localparam int V_TOT  = 10;
  localparam int V_SYNC = 2;
  localparam int V_ACT0 = 3;
  localparam int V_ACT  = 6;

  localparam int K_N = 0;  // normal frame
  localparam int K_S = 1;  // line 4 shortened by one clock
  localparam int K_L = 2;  // three lines then hsync held high
  localparam int K_R = 3;  // reset asserted mid-frame, released mid-line

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vga_hsync = 1'b1;
  logic        vga_vsync = 1'b1;
  logic        display_on = 1'b0;
  logic        pixel_valid;
  logic [9:0]  x_addr;
  logic [9:0]  y_addr;
  logic [18:0] pixel_addr;
  logic [9:0]  h_period;
  logic [9:0]  v_lines;
  logic        frame_start;
  logic        locked;
  logic        timing_err;

  vga_sync_decoder #(
    .H_SIZE(10), .V_SIZE(10), .P_SIZE(19),
    .EXP_H_COUNT(H_TOT), .EXP_V_COUNT(V_TOT), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .display_on(display_on),
    .pixel_valid(pixel_valid), .x_addr(x_addr), .y_addr(y_addr), .pixel_addr(pixel_addr),
    .h_period(h_period), .v_lines(v_lines), .frame_start(frame_start),
    .locked(locked), .timing_err(timing_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int valid;
    int x;
    int y;
    int addr;
    int tag;
  } exp_t;

  typedef struct {
    int kind;
    int exp_lk;
    int exp_lk_prev;
    int exp_vl;
    int exp_hp;
    int exp_errs;
    int exp_end_lk;
  } rec_t;

  int   tests = 0;
  int   failed = 0;
  int   coord_err = 0;
  bit   coord_chk = 1'b0;
  exp_t pipe [2];

  int   fs_cnt = 0, err_cnt = 0, pulse_viol = 0;
  int   fs_locked = 0, fs_lk_prev = 0, fs_vlines = 0, fs_hper = 0, err_hper = 0;
  logic fs_q = 1'b0, te_q = 1'b0, lk_q = 1'b0;

  always @(negedge clk) begin
    if (frame_start) begin
      fs_cnt++;
      fs_locked  = int'(locked);
      fs_lk_prev = int'(lk_q);
      fs_vlines  = int'(v_lines);
      fs_hper    = int'(h_period);
    end
    if (timing_err) begin
      err_cnt++;
      err_hper = int'(h_period);
    end
    if ((frame_start && fs_q) || (timing_err && te_q)) pulse_viol++;
    fs_q = frame_start;
    te_q = timing_err;
    lk_q = locked;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required completion before it");
    $fatal(1);
  end

  task automatic chk(input string name, input longint got, input longint want);
    tests++;
    if (got !== want) begin
      failed++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic check_pipe(input exp_t e);
    if (pixel_valid !== (e.valid != 0)) coord_err++;
    else if (e.valid != 0 && (int'(x_addr) != e.x || int'(y_addr) != e.y ||
                              int'(pixel_addr) != e.addr)) coord_err++;
    if (e.tag != 0) begin
      chk(e.tag == 1 ? "first_px_valid" : "last_px_valid", pixel_valid, 1);
      chk(e.tag == 1 ? "first_px_x"     : "last_px_x",     x_addr,      e.x);
      chk(e.tag == 1 ? "first_px_y"     : "last_px_y",     y_addr,      e.y);
      chk(e.tag == 1 ? "first_px_addr"  : "last_px_addr",  pixel_addr,  e.addr);
    end
  endtask

  // Inputs change on the falling edge; the outputs they cause are seen two steps later
  task automatic drive(input logic hs, input logic vs, input logic de, input exp_t e);
    @(negedge clk);
    if (coord_chk) check_pipe(pipe[1]);
    pipe[1]    = pipe[0];
    pipe[0]    = e;
    vga_hsync  = hs;
    vga_vsync  = vs;
    display_on = de;
  endtask

  task automatic gen_line(input int vc, input int len, input int rel_hc);
    for (int hc = 0; hc < len; hc++) begin
      exp_t e;
      logic de;
      de      = (vc >= V_ACT0) && (vc < V_ACT0 + V_ACT) && (hc >= H_ACT0) && (hc < H_ACT0 + H_ACT);
      e.valid = int'(de);
      e.x     = hc - H_ACT0;
      e.y     = vc - V_ACT0;
      e.addr  = e.y * H_ACT + e.x;
      e.tag   = (vc == V_ACT0 && hc == H_ACT0) ? 1 :
                (vc == V_ACT0 + V_ACT - 1 && hc == H_ACT0 + H_ACT - 1) ? 2 : 0;
      drive(hc >= H_SYNC, vc >= V_SYNC, de, e);
      if (hc == rel_hc) rst_n = 1'b1;
    end
  endtask

  task automatic run_frame(input int kind);
    exp_t idle;
    int   seen;
    idle = '{0, 0, 0, 0, 0};
    coord_chk = 1'b1;
    case (kind)
      K_S: begin
        for (int vc = 0; vc < V_TOT; vc++) gen_line(vc, (vc == 4) ? H_TOT - 1 : H_TOT, -1);
        chk("short_line_period", err_hper, H_TOT - 1);
      end
      K_L: begin
        for (int vc = 0; vc < 3; vc++) gen_line(vc, H_TOT, -1);
        seen = -1;
        for (int j = 0; j < 3 * H_TOT; j++) begin
          drive(1'b1, 1'b1, 1'b0, idle);
          if (timing_err && seen < 0) seen = H_TOT + j;
        end
        // h_cnt reaches 2*H_TOT-1, plus input and error register latency
        chk("loss_latency", seen, 2 * H_TOT + 2);
      end
      K_R: begin
        for (int vc = 0; vc < 5; vc++) gen_line(vc, H_TOT, -1);
        #3 rst_n = 1'b0;
        coord_chk = 1'b0;
        #1 chk("async_reset_outputs",
               {pixel_valid, x_addr, y_addr, pixel_addr, h_period, v_lines,
                frame_start, locked, timing_err}, 0);
        gen_line(5, H_TOT, H_ACT0 + 3);
        for (int vc = 6; vc < V_TOT; vc++) gen_line(vc, H_TOT, -1);
      end
      default: begin
        for (int vc = 0; vc < V_TOT; vc++) gen_line(vc, H_TOT, -1);
      end
    endcase
  endtask

  rec_t tbl [16];

  initial begin
    int fs0, e0;
    exp_t idle;
    idle = '{0, 0, 0, 0, 0};
    pipe[0] = idle;
    pipe[1] = idle;

    tbl[0]  = '{K_N, 0, 0, -1, -1, 0, 0};
    tbl[1]  = '{K_N, 0, 0, 10, 20, 0, 0};
    tbl[2]  = '{K_N, 1, 0, 10, 20, 0, 1};
    tbl[3]  = '{K_N, 1, 1, 10, 20, 0, 1};
    tbl[4]  = '{K_S, 1, 1, 10, 20, 1, 0};
    tbl[5]  = '{K_N, 0, 0, 10, 20, 0, 0};
    tbl[6]  = '{K_N, 0, 0, 10, 20, 0, 0};
    tbl[7]  = '{K_N, 1, 0, 10, 20, 0, 1};
    tbl[8]  = '{K_L, 1, 1, 10, 20, 1, 0};
    tbl[9]  = '{K_N, 0, 0, -1, -1, 0, 0};
    tbl[10] = '{K_N, 0, 0, 10, 20, 0, 0};
    tbl[11] = '{K_N, 1, 0, 10, 20, 0, 1};
    tbl[12] = '{K_R, 1, 1, 10, 20, 0, 0};
    tbl[13] = '{K_N, 0, 0, -1, -1, 0, 0};
    tbl[14] = '{K_N, 0, 0, 10, 20, 0, 0};
    tbl[15] = '{K_N, 1, 0, 10, 20, 0, 1};

    repeat (5) @(negedge clk);
    chk("reset_outputs",
        {pixel_valid, x_addr, y_addr, pixel_addr, h_period, v_lines,
         frame_start, locked, timing_err}, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 30; i++) drive(1'b1, 1'b1, 1'b0, idle);
    chk("idle_outputs",
        {pixel_valid, x_addr, y_addr, pixel_addr, h_period, v_lines,
         frame_start, locked, timing_err}, 0);
    chk("idle_frame_starts", fs_cnt, 0);
    chk("idle_timing_errs", err_cnt, 0);

    for (int i = 0; i < 16; i++) begin
      fs0 = fs_cnt;
      e0  = err_cnt;
      run_frame(tbl[i].kind);
      chk($sformatf("f%0d_frame_start_count", i), fs_cnt - fs0, 1);
      chk($sformatf("f%0d_locked_at_fs", i), fs_locked, tbl[i].exp_lk);
      chk($sformatf("f%0d_locked_before_fs", i), fs_lk_prev, tbl[i].exp_lk_prev);
      if (tbl[i].exp_vl >= 0) chk($sformatf("f%0d_v_lines", i), fs_vlines, tbl[i].exp_vl);
      if (tbl[i].exp_hp >= 0) chk($sformatf("f%0d_h_period", i), fs_hper, tbl[i].exp_hp);
      chk($sformatf("f%0d_timing_errs", i), err_cnt - e0, tbl[i].exp_errs);
      chk($sformatf("f%0d_locked_end", i), locked, tbl[i].exp_end_lk);
      chk($sformatf("f%0d_coord_errors", i), coord_err, 0);
      coord_err = 0;
    end

    chk("pulse_width_violations", pulse_viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
